text_renderer: RTL and testbench

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_renderer_pkg.sv | 21 ++
 rtl/text_renderer_if.sv | 29 ++
 rtl/text_ram.sv | 21 ++
 rtl/text_renderer.sv | 120 ++++++++++++
 tb/tb_text_renderer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_renderer_pkg.sv
// Shared constants and helpers for the VGA text renderer.
// Glyph cells are 8 pixels wide and 16 lines tall.
package text_renderer_pkg;

    localparam int unsigned TextCols  = 80;
    localparam int unsigned TextRows  = 30;
    localparam int unsigned CharCount = 41;
    localparam int unsigned GlyphH    = 16;
    localparam int unsigned GlyphW    = 8;
    localparam int unsigned CellCount = TextCols * TextRows;
    localparam int unsigned CellAddrW = 12;
    localparam int unsigned CodeW     = 6;

    // Linear cell index for a pixel position. The shifts assume 8x16 glyphs.
    function automatic logic [CellAddrW-1:0] cell_index(input logic [9:0] x,
                                                        input logic [9:0] y,
                                                        input int unsigned cols);
        return CellAddrW'(y[9:4]) * CellAddrW'(cols) + CellAddrW'(x[9:3]);
    endfunction

endpackage

// File: rtl/text_renderer_if.sv
// Text-buffer bus: one write port and one registered read port.
interface text_renderer_if #(
    parameter int unsigned AddrWidth = 12,
    parameter int unsigned DataWidth = 6
);

    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic [AddrWidth-1:0] rd_addr;
    logic [DataWidth-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/text_ram.sv
// Character-code store for the text screen: 1W/1R, registered read, no reset.
// A read of the cell being written returns the old code.
module text_ram
    import text_renderer_pkg::*;
#(
    parameter int unsigned Depth = CellCount
) (
    input logic             clk_i,
    text_renderer_if.slave  bus
);

    logic [CodeW-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (bus.wr_en && (bus.wr_addr < CellAddrW'(Depth))) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        bus.rd_data <= mem[bus.rd_addr];
    end

endmodule

// File: rtl/text_renderer.sv
// Three-stage text-mode pixel pipeline: cell lookup, glyph ROM address, pixel select.
// Timing strobes travel alongside so o_de/o_hsync/o_vsync stay aligned with o_pixel.
module text_renderer
    import text_renderer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHAR_COUNT = CharCount,
    parameter int unsigned TEXT_COLS  = TextCols,
    parameter int unsigned TEXT_ROWS  = TextRows
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [9:0]            i_pix_x,
    input  logic [9:0]            i_pix_y,
    input  logic                  i_de,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_wr_en,
    input  logic [11:0]           i_wr_addr,
    input  logic [5:0]            i_wr_char,
    output logic [ADDR_WIDTH-1:0] o_char_addr,
    input  logic [DATA_WIDTH-1:0] i_char_strip,
    output logic                  o_pixel,
    output logic                  o_de,
    output logic                  o_hsync,
    output logic                  o_vsync
);

    localparam int unsigned Cells = TEXT_COLS * TEXT_ROWS;
    localparam int unsigned XLim  = TEXT_COLS * GlyphW;
    localparam int unsigned YLim  = TEXT_ROWS * GlyphH;

    text_renderer_if #(
        .AddrWidth(CellAddrW),
        .DataWidth(CodeW)
    ) ram_bus ();

    text_ram #(
        .Depth(Cells)
    ) u_text_ram (
        .clk_i(i_clk),
        .bus  (ram_bus)
    );

    logic                  in_range;
    logic [CodeW-1:0]      code;
    logic                  blank_d;
    logic [ADDR_WIDTH-1:0] char_addr_d;
    logic [2:0]            bit_sel;
    logic                  pixel_d;

    logic [2:0]            s1_x_q;
    logic [3:0]            s1_y_q;
    logic                  s1_de_q, s1_hs_q, s1_vs_q;
    logic [2:0]            s2_x_q;
    logic                  s2_blank_q, s2_de_q, s2_hs_q, s2_vs_q;
    logic [ADDR_WIDTH-1:0] char_addr_q;
    logic                  pixel_q, de_q, hs_q, vs_q;

    // Off-screen positions read cell 0 and are rendered as blanking.
    always_comb begin
        in_range         = (32'(i_pix_x) < XLim) && (32'(i_pix_y) < YLim);
        ram_bus.rd_addr  = in_range ? cell_index(i_pix_x, i_pix_y, TEXT_COLS) : '0;
        ram_bus.wr_en    = i_wr_en;
        ram_bus.wr_addr  = i_wr_addr;
        ram_bus.wr_data  = i_wr_char;
    end

    always_comb begin
        code        = ram_bus.rd_data;
        blank_d     = 32'(code) >= CHAR_COUNT;
        char_addr_d = blank_d ? '0 : ADDR_WIDTH'({code, s1_y_q});
        bit_sel     = 3'(DATA_WIDTH - 1) - s2_x_q;
        pixel_d     = s2_de_q & ~s2_blank_q & i_char_strip[bit_sel];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_de_q     <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            s2_x_q      <= '0;
            s2_blank_q  <= 1'b0;
            s2_de_q     <= 1'b0;
            s2_hs_q     <= 1'b0;
            s2_vs_q     <= 1'b0;
            char_addr_q <= '0;
            pixel_q     <= 1'b0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            s1_x_q      <= i_pix_x[2:0];
            s1_y_q      <= i_pix_y[3:0];
            s1_de_q     <= i_de & in_range;
            s1_hs_q     <= i_hsync;
            s1_vs_q     <= i_vsync;
            s2_x_q      <= s1_x_q;
            s2_blank_q  <= blank_d;
            s2_de_q     <= s1_de_q;
            s2_hs_q     <= s1_hs_q;
            s2_vs_q     <= s1_vs_q;
            char_addr_q <= char_addr_d;
            pixel_q     <= pixel_d;
            de_q        <= s2_de_q;
            hs_q        <= s2_hs_q;
            vs_q        <= s2_vs_q;
        end
    end

    assign o_char_addr = char_addr_q;
    assign o_pixel     = pixel_q;
    assign o_de        = de_q;
    assign o_hsync     = hs_q;
    assign o_vsync     = vs_q;

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer with a combinational glyph ROM model.
// ROM strip = addr[7:0] ^ 8'hC3, so addr 83 -> 8'h90, addr 80 -> 8'h93, addr 655 -> 8'h4C.
module tb_text_renderer;

    logic       clk;
    logic       rst_n;
    logic [9:0] pix_x, pix_y;
    logic       de, hsync, vsync;
    logic       wr_en;
    logic [11:0] wr_addr;
    logic [5:0] wr_char;
    logic [9:0] char_addr;
    logic [7:0] char_strip;
    logic       pixel, de_o, hsync_o, vsync_o;

    int checks   = 0;
    int failures = 0;

    text_renderer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pix_x     (pix_x),
        .i_pix_y     (pix_y),
        .i_de        (de),
        .i_hsync     (hsync),
        .i_vsync     (vsync),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_char   (wr_char),
        .o_char_addr (char_addr),
        .i_char_strip(char_strip),
        .o_pixel     (pixel),
        .o_de        (de_o),
        .o_hsync     (hsync_o),
        .o_vsync     (vsync_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign char_strip = char_addr[7:0] ^ 8'hC3;

    task automatic set_pix(input int x, input int y, input logic d, input logic hs,
                           input logic vs);
        pix_x = 10'(x);
        pix_y = 10'(y);
        de    = d;
        hsync = hs;
        vsync = vs;
    endtask

    task automatic write_cell(input int addr, input int code);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 12'(addr);
        wr_char = 6'(code);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks += 5;
        if (char_addr !== 10'd0) begin
            failures++; $display("FAIL reset_addr got=%0d exp=0", char_addr);
        end
        if (pixel !== 1'b0) begin failures++; $display("FAIL reset_pixel got=%b exp=0", pixel); end
        if (de_o !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", de_o); end
        if (hsync_o !== 1'b0) begin
            failures++; $display("FAIL reset_hsync got=%b exp=0", hsync_o);
        end
        if (vsync_o !== 1'b0) begin
            failures++; $display("FAIL reset_vsync got=%b exp=0", vsync_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_glyph;
        logic [7:0] strip;
        strip = 8'h90;
        write_cell(0, 5);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 9) begin
                checks++;
                if (char_addr !== 10'd83) begin
                    failures++; $display("FAIL glyph_addr c=%0d got=%0d exp=83", c, char_addr);
                end
            end
            if (c >= 3) begin
                checks += 2;
                if (pixel !== strip[7-(c-3)]) begin
                    failures++;
                    $display("FAIL glyph_pixel x=%0d got=%b exp=%b", c - 3, pixel, strip[7-(c-3)]);
                end
                if (de_o !== 1'b1) begin
                    failures++; $display("FAIL glyph_de c=%0d got=%b exp=1", c, de_o);
                end
            end
            if (c < 8) set_pix(c, 3, 1'b1, 1'b0, 1'b0);
            else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_max_cell;
        write_cell(2399, 40);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (char_addr !== 10'd655) begin
                    failures++; $display("FAIL max_addr got=%0d exp=655", char_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (pixel !== 1'b1) begin failures++; $display("FAIL max_pixel got=%b exp=1", pixel); end
            end
            if (c == 0) set_pix(633, 479, 1'b1, 1'b0, 1'b0);
            else        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_blank;
        write_cell(1, 50);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (char_addr !== 10'd80) begin
                    failures++; $display("FAIL blank_lead_addr got=%0d exp=80", char_addr);
                end
            end
            if (c >= 3 && c <= 10) begin
                checks++;
                if (char_addr !== 10'd0) begin
                    failures++; $display("FAIL blank_addr c=%0d got=%0d exp=0", c, char_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (pixel !== 1'b1) begin
                    failures++; $display("FAIL blank_lead_pixel got=%b exp=1", pixel);
                end
            end
            if (c >= 4) begin
                checks++;
                if (pixel !== 1'b0) begin
                    failures++; $display("FAIL blank_pixel c=%0d got=%b exp=0", c, pixel);
                end
            end
            if (c < 9) set_pix(7 + c, 0, 1'b1, 1'b0, 1'b0);
            else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_same_cell;
        write_cell(10, 7);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (char_addr !== 10'd114) begin
                    failures++; $display("FAIL same_cell_old got=%0d exp=114", char_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (char_addr !== 10'd146) begin
                    failures++; $display("FAIL same_cell_new got=%0d exp=146", char_addr);
                end
            end
            wr_en = 1'b0;
            if (c == 0) begin
                set_pix(80, 2, 1'b1, 1'b0, 1'b0);
                wr_en   = 1'b1;
                wr_addr = 12'd10;
                wr_char = 6'd9;
            end else if (c == 1) begin
                set_pix(81, 2, 1'b1, 1'b0, 1'b0);
            end else begin
                set_pix(0, 0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_sync;
        logic [7:0] hs_pat, vs_pat;
        hs_pat = 8'b1011_0010;
        vs_pat = 8'b0110_1100;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks += 4;
                if (hsync_o !== hs_pat[c-3]) begin
                    failures++;
                    $display("FAIL sync_hs c=%0d got=%b exp=%b", c, hsync_o, hs_pat[c-3]);
                end
                if (vsync_o !== vs_pat[c-3]) begin
                    failures++;
                    $display("FAIL sync_vs c=%0d got=%b exp=%b", c, vsync_o, vs_pat[c-3]);
                end
                if (pixel !== 1'b0) begin
                    failures++; $display("FAIL sync_pixel c=%0d got=%b exp=0", c, pixel);
                end
                if (de_o !== 1'b0) begin
                    failures++; $display("FAIL sync_de c=%0d got=%b exp=0", c, de_o);
                end
            end
            if (c < 8) set_pix(c, 3, 1'b0, hs_pat[c], vs_pat[c]);
            else       set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_out_of_range;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (char_addr !== 10'd90) begin
                    failures++; $display("FAIL oor_addr got=%0d exp=90", char_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (pixel !== 1'b0) begin failures++; $display("FAIL oor_pixel got=%b exp=0", pixel); end
            end
            if (c == 0) set_pix(700, 10, 1'b1, 1'b0, 1'b0);
            else        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks += 2;
                if (pixel !== 1'b1) begin failures++; $display("FAIL mid_pre_pixel got=%b exp=1", pixel); end
                if (de_o !== 1'b1) begin failures++; $display("FAIL mid_pre_de got=%b exp=1", de_o); end
            end
            set_pix(c, 3, 1'b1, 1'b1, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (char_addr !== 10'd0) begin failures++; $display("FAIL mid_addr got=%0d exp=0", char_addr); end
        if (pixel !== 1'b0) begin failures++; $display("FAIL mid_pixel got=%b exp=0", pixel); end
        if (de_o !== 1'b0) begin failures++; $display("FAIL mid_de got=%b exp=0", de_o); end
        if (hsync_o !== 1'b0) begin failures++; $display("FAIL mid_hsync got=%b exp=0", hsync_o); end
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        set_pix(0, 3, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks += 2;
                if (char_addr !== 10'd83) begin
                    failures++; $display("FAIL post_rst_addr got=%0d exp=83", char_addr);
                end
                if (de_o !== 1'b0) begin failures++; $display("FAIL post_rst_early_de got=%b exp=0", de_o); end
            end
            if (c == 3) begin
                checks += 2;
                if (pixel !== 1'b1) begin failures++; $display("FAIL post_rst_pixel got=%b exp=1", pixel); end
                if (de_o !== 1'b1) begin failures++; $display("FAIL post_rst_de got=%b exp=1", de_o); end
            end
            set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_char = '0;
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_glyph();
        test_max_cell();
        test_blank();
        test_same_cell();
        test_sync();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
